// File: rtl/dkong_obj_linebuf_if.sv
// Renderer write channel into the object line buffer.
// The renderer drives the request, address and pixel; the line buffer returns ready.
interface dkong_obj_linebuf_if #(
  parameter int XW = 8,
  parameter int PW = 6
);
  logic          I_WR_REQ;
  logic [XW-1:0] I_WR_X;
  logic [PW-1:0] I_WR_PIX;
  logic          O_WR_RDY;

  modport master (output I_WR_REQ, I_WR_X, I_WR_PIX, input O_WR_RDY);
  modport slave  (input I_WR_REQ, I_WR_X, I_WR_PIX, output O_WR_RDY);
endinterface

// File: rtl/dkong_obj_linebuf.sv
// Double-buffered sprite line buffer: one bank is read-then-cleared for display, the other takes renderer writes.
// Optional macro DKONG_OBJ_PRIO_EN enables first-writer-wins priority through a 2-state write FSM.
//
//   state   | meaning
//   S_CLEAR | sweeping zeros into both banks after reset, writes and line swaps blocked
//   S_RUN   | normal display readout / render write operation
//   W_IDLE  | (priority build) ready, accept captures address, pixel and stored entry
//   W_CMP   | (priority build) commit only if the stored entry is transparent
module dkong_obj_linebuf #(
  parameter int XW = 8,
  parameter int PW = 6
) (
  input  logic                 I_CLK,
  input  logic                 I_RST,
  input  logic                 I_CLK_EN,
  input  logic [XW-1:0]        I_HPOS,
  input  logic                 I_H_BLANKn,
  input  logic                 I_LINE_START,
  dkong_obj_linebuf_if.slave   wr,
  output logic [PW-1:0]        O_OBJ_PIX,
  output logic                 O_BANK,
  output logic                 O_CLR_BUSY
);
  localparam int DEPTH = 1 << XW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t state_q, state_d;

  logic [PW-1:0] mem [2][DEPTH];
  logic [XW-1:0] clr_addr_q;
  logic          bank_q;
  logic          rd_v_q, rd_vis_q, rd_bank_q;
  logic [XW-1:0] rd_addr_q;
  logic [PW-1:0] rd_data_q, obj_pix_q;

  logic          run;
  logic          wr_rdy, wr_commit, wr_bank;
  logic [XW-1:0] wr_addr;
  logic [PW-1:0] wr_data;

  assign run        = (state_q == S_RUN);
  assign O_BANK     = bank_q;
  assign O_OBJ_PIX  = obj_pix_q;
  assign O_CLR_BUSY = (state_q == S_CLEAR);
  assign wr.O_WR_RDY = wr_rdy;

  always_ff @(posedge I_CLK) begin
    if (I_RST) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_addr_q == '1) state_d = S_RUN;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      clr_addr_q <= '0;
      bank_q     <= 1'b0;
      rd_v_q     <= 1'b0;
      rd_vis_q   <= 1'b0;
      obj_pix_q  <= '0;
    end else begin
      if (!run) clr_addr_q <= clr_addr_q + 1'b1;
      if (run && I_LINE_START) bank_q <= ~bank_q;
      rd_v_q   <= run && I_CLK_EN;
      rd_vis_q <= I_H_BLANKn;
      if (rd_v_q) obj_pix_q <= rd_vis_q ? rd_data_q : '0;
    end
  end

`ifdef DKONG_OBJ_PRIO_EN
  typedef enum logic {W_IDLE, W_CMP} wstate_t;
  wstate_t       w_state_q, w_state_d;
  logic [XW-1:0] w_addr_q;
  logic [PW-1:0] w_pix_q, w_old_q;
  logic          w_bank_q;
  logic          w_acc;

  assign w_acc = wr.I_WR_REQ && wr_rdy;

  always_ff @(posedge I_CLK) begin
    if (I_RST) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    wr_rdy    = 1'b0;
    wr_commit = 1'b0;
    wr_bank   = w_bank_q;
    wr_addr   = w_addr_q;
    wr_data   = w_pix_q;
    case (w_state_q)
      W_IDLE: begin
        wr_rdy = run && !I_LINE_START;
        if (wr.I_WR_REQ && wr_rdy) w_state_d = W_CMP;
      end
      W_CMP: begin
        w_state_d = W_IDLE;
        wr_commit = run && (w_old_q[1:0] == 2'b00) && (w_pix_q[1:0] != 2'b00);
      end
      default: w_state_d = W_IDLE;
    endcase
  end
`else
  always_comb begin
    wr_rdy    = run && !I_LINE_START;
    wr_commit = wr.I_WR_REQ && wr_rdy && (wr.I_WR_PIX[1:0] != 2'b00);
    wr_bank   = ~bank_q;
    wr_addr   = wr.I_WR_X;
    wr_data   = wr.I_WR_PIX;
  end
`endif

  // Storage: clear sweep, render write to ~bank, and read-then-clear on the display bank.
  always_ff @(posedge I_CLK) begin
    if (run && I_CLK_EN) begin
      rd_data_q <= mem[bank_q][I_HPOS];
      rd_addr_q <= I_HPOS;
      rd_bank_q <= bank_q;
    end
`ifdef DKONG_OBJ_PRIO_EN
    if (w_acc) begin
      w_addr_q <= wr.I_WR_X;
      w_pix_q  <= wr.I_WR_PIX;
      w_bank_q <= ~bank_q;
      w_old_q  <= mem[~bank_q][wr.I_WR_X];
    end
`endif
    if (!I_RST) begin
      if (!run) begin
        mem[1'b0][clr_addr_q] <= '0;
        mem[1'b1][clr_addr_q] <= '0;
      end else begin
        if (wr_commit) mem[wr_bank][wr_addr] <= wr_data;
        if (rd_v_q && rd_vis_q) mem[rd_bank_q][rd_addr_q] <= '0;
      end
    end
  end
endmodule
